mem_read_scheduler: RTL and testbench

- Shares one external-memory read dispatcher (os_start/busy handshake, one line per request) between N_REQ line-buffer clients, e.g. current frame, background model and previous mask.
- Grants clients round-robin and keeps a per-client line counter and address offset.
- Generates each transfer's start address and returns one done pulse per line to the requesting client.
- Sits between the segmentation pipeline line fetchers and the read dispatcher.

---
 rtl/mem_sched_pkg.sv | 12 +
 rtl/rr_arbiter_onehot.sv | 39 +++
 rtl/mem_read_scheduler.sv | 119 +++++++++++
 tb/tb_mem_read_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the line-fetch read scheduler.
package mem_sched_pkg;
   localparam int ADDR_W = 30;

   typedef enum logic [2:0] {
      ST_CALIB, ST_ARB, ST_START, ST_ACK, ST_XFER, ST_DONE
   } sched_state_t;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction
endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin picker: first requester at or after the pointer; pointer moves past the last winner.
module rr_arbiter_onehot
   import mem_sched_pkg::*;
#(
   parameter int N_REQ = 3,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             enable,
   input  logic [IDX_W-1:0] last_idx,
   output logic [N_REQ-1:0] grant_oh,
   output logic [IDX_W-1:0] grant_idx
);
   logic [IDX_W-1:0] ptr;
   logic             found;
   int               j;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr <= '0;
      else if (enable) ptr <= IDX_W'(rr_next(32'(last_idx), $unsigned(N_REQ)));
   end

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!found && req[j]) begin
            found       = 1'b1;
            grant_oh[j] = 1'b1;
            grant_idx   = IDX_W'(j);
         end
      end
   end
endmodule

// File: rtl/mem_read_scheduler.sv
// Shares one line-read dispatcher between N_REQ line-buffer clients, stepping each
// client's line address through its frame and returning a done pulse per line.
module mem_read_scheduler
   import mem_sched_pkg::*;
#(
   parameter int N_REQ           = 3,
   parameter int LINE_BYTES      = 2560,
   parameter int LINES_PER_FRAME = 480,
   parameter int LINE_BITS       = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_calib_done,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        frame_restart,
   input  logic [ADDR_W*N_REQ-1:0] base_addr,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        done,
   output logic [N_REQ-1:0]        frame_done,
   output logic [LINE_BITS-1:0]    line_idx,
   output logic                    rd_start,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic                    rd_busy
);
   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [LINE_BITS-1:0] LAST_LINE = LINE_BITS'(LINES_PER_FRAME - 1);
   localparam logic [ADDR_W-1:0]    LINE_INC  = ADDR_W'(LINE_BYTES);

   sched_state_t                     state;
   logic [N_REQ-1:0][ADDR_W-1:0]     base_v;
   logic [N_REQ-1:0][ADDR_W-1:0]     offset;
   logic [N_REQ-1:0][LINE_BITS-1:0]  line_cnt;
   logic [N_REQ-1:0]                 pend;
   logic [IDX_W-1:0]                 sel;
   logic [IDX_W-1:0]                 arb_idx;
   logic [N_REQ-1:0]                 arb_oh;
   logic                             xfer_end;

   assign base_v   = base_addr;
   assign xfer_end = (state == ST_XFER) && !rd_busy;

   rr_arbiter_onehot #(.N_REQ(N_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .enable    (xfer_end),
      .last_idx  (sel),
      .grant_oh  (arb_oh),
      .grant_idx (arb_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_CALIB;
         grant      <= '0;
         done       <= '0;
         frame_done <= '0;
         line_idx   <= '0;
         rd_start   <= 1'b0;
         rd_addr    <= '0;
         sel        <= '0;
         offset     <= '0;
         line_cnt   <= '0;
         pend       <= '0;
      end else begin
         rd_start   <= 1'b0;
         done       <= '0;
         frame_done <= '0;
         // Idle clients restart at once; the owner defers it to line completion.
         for (int i = 0; i < N_REQ; i++) begin
            if (frame_restart[i]) begin
               if (grant[i]) pend[i] <= 1'b1;
               else begin
                  line_cnt[i] <= '0;
                  offset[i]   <= '0;
                  pend[i]     <= 1'b0;
               end
            end
         end
         case (state)
            ST_CALIB: if (mem_calib_done && !rd_busy) state <= ST_ARB;
            ST_ARB: begin
               if (!mem_calib_done) state <= ST_CALIB;
               else if (|req) begin
                  grant    <= arb_oh;
                  sel      <= arb_idx;
                  rd_addr  <= base_v[arb_idx] + offset[arb_idx];
                  line_idx <= line_cnt[arb_idx];
                  rd_start <= 1'b1;
                  state    <= ST_START;
               end
            end
            ST_START: state <= ST_ACK;
            ST_ACK:   if (rd_busy) state <= ST_XFER;
            ST_XFER: begin
               if (!rd_busy) begin
                  done[sel] <= 1'b1;
                  grant     <= '0;
                  state     <= ST_DONE;
                  if (pend[sel] || frame_restart[sel]) begin
                     line_cnt[sel] <= '0;
                     offset[sel]   <= '0;
                     pend[sel]     <= 1'b0;
                  end else if (line_cnt[sel] == LAST_LINE) begin
                     line_cnt[sel]   <= '0;
                     offset[sel]     <= '0;
                     frame_done[sel] <= 1'b1;
                  end else begin
                     line_cnt[sel] <= line_cnt[sel] + 1'b1;
                     offset[sel]   <= offset[sel] + LINE_INC;
                  end
               end
            end
            ST_DONE: state <= mem_calib_done ? ST_ARB : ST_CALIB;
            default: state <= ST_CALIB;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_read_scheduler.sv
// Directed bench for mem_read_scheduler with a 10-cycle dispatcher model.
module tb_mem_read_scheduler;
   localparam int N     = 3;
   localparam int LBITS = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             mem_calib_done = 1'b0;
   logic             rd_busy;
   logic [N-1:0]     req = '0, frame_restart = '0;
   logic [N-1:0]     grant, done, frame_done;
   logic [30*N-1:0]  base_addr;
   logic [LBITS-1:0] line_idx;
   logic             rd_start;
   logic [29:0]      rd_addr;

   int tests = 0, fails = 0, cyc = 0, bcnt;

   logic [29:0]      st_addr[$];
   logic [LBITS-1:0] st_line[$];
   logic [N-1:0]     st_grant[$];
   int               st_cyc[$];
   logic [N-1:0]     dn_val[$], fd_val[$];

   always #5 clk = ~clk;

   mem_read_scheduler #(.N_REQ(N), .LINE_BYTES(2560), .LINES_PER_FRAME(4), .LINE_BITS(LBITS)) dut (
      .clk(clk), .rst(rst), .mem_calib_done(mem_calib_done), .req(req),
      .frame_restart(frame_restart), .base_addr(base_addr), .grant(grant), .done(done),
      .frame_done(frame_done), .line_idx(line_idx), .rd_start(rd_start), .rd_addr(rd_addr),
      .rd_busy(rd_busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Dispatcher: busy rises the cycle after os_start and stays high 10 cycles.
   always @(posedge clk or posedge rst)
      if (rst) begin bcnt <= 0; rd_busy <= 1'b0; end
      else if (rd_start) begin bcnt <= 10; rd_busy <= 1'b1; end
      else if (bcnt > 1) bcnt <= bcnt - 1;
      else begin bcnt <= 0; rd_busy <= 1'b0; end

   always @(posedge clk) begin
      #1;
      if (rd_start) begin
         st_addr.push_back(rd_addr); st_line.push_back(line_idx);
         st_grant.push_back(grant);  st_cyc.push_back(cyc);
      end
      if (|done) begin dn_val.push_back(done); fd_val.push_back(frame_done); end
   end

   task automatic clear_logs();
      st_addr.delete(); st_line.delete(); st_grant.delete(); st_cyc.delete();
      dn_val.delete(); fd_val.delete();
   endtask

   task automatic drive_line(input logic [N-1:0] mask, input int restart_at,
                             output logic [29:0] a, output logic [LBITS-1:0] l,
                             output logic [N-1:0] d, output logic [N-1:0] f, output bit ok);
      int k = 0;
      clear_logs();
      req = mask; ok = 1'b0; a = '0; l = '0; d = '0; f = '0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         frame_restart = '0;
         if (st_addr.size() > 0) begin
            if (k == restart_at) frame_restart = mask;
            k++;
         end
         if (dn_val.size() > 0) begin ok = 1'b1; break; end
      end
      req = '0; frame_restart = '0;
      if (ok) begin a = st_addr[0]; l = st_line[0]; d = dn_val[0]; f = fd_val[0]; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({grant, done, frame_done, line_idx, rd_start, rd_addr} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got grant=%b done=%b fd=%b line=%0d start=%b addr=%h, expected all 0",
                  grant, done, frame_done, line_idx, rd_start, rd_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_calib_gate();
      int c0;
      clear_logs();
      req = 3'b001;
      repeat (20) @(negedge clk);
      tests++;
      if (st_addr.size() != 0) begin
         fails++; $display("FAIL calib_gate_no_start: got %0d starts, expected 0", st_addr.size());
      end
      c0 = cyc;
      mem_calib_done = 1'b1;
      for (int t = 0; t < 50 && st_addr.size() < 1; t++) @(negedge clk);
      tests++;
      if (st_addr.size() < 1) begin
         fails++; $display("FAIL calib_gate_timeout: got no rd_start, expected one");
      end else begin
         tests++;
         if (st_cyc[0] - c0 != 2) begin
            fails++; $display("FAIL calib_gate_latency: got %0d cycles, expected 2", st_cyc[0] - c0);
         end
         tests++;
         if (st_addr[0] !== 30'h1000) begin
            fails++; $display("FAIL calib_gate_addr: got %h, expected 00001000", st_addr[0]);
         end
         tests++;
         if (st_grant[0] !== 3'b001) begin
            fails++; $display("FAIL calib_gate_grant: got %b, expected 001", st_grant[0]);
         end
      end
      for (int t = 0; t < 50 && dn_val.size() < 1; t++) @(negedge clk);
      req = '0;
      tests++;
      if (dn_val.size() < 1 || dn_val[0] !== 3'b001) begin
         fails++; $display("FAIL calib_gate_done: got %0d pulses, expected done=001", dn_val.size());
      end
   endtask

   task automatic test_line_step();
      logic [29:0]      ea [5] = '{30'h1000, 30'h1A00, 30'h2400, 30'h2E00, 30'h1000};
      logic [29:0]      a;
      logic [LBITS-1:0] l;
      logic [N-1:0]     d, f;
      bit               ok;
      // client 0 sits on line 1 here; an idle restart puts it back on line 0
      frame_restart = 3'b001;
      @(negedge clk);
      frame_restart = '0;
      for (int i = 0; i < 5; i++) begin
         drive_line(3'b001, -1, a, l, d, f, ok);
         tests++;
         if (!ok) begin fails++; $display("FAIL step_timeout[%0d]: got no done, expected one", i); end
         tests++;
         if (a !== ea[i]) begin fails++; $display("FAIL step_addr[%0d]: got %h, expected %h", i, a, ea[i]); end
         tests++;
         if (l !== LBITS'(i % 4)) begin fails++; $display("FAIL step_line[%0d]: got %0d, expected %0d", i, l, i % 4); end
         tests++;
         if (f !== ((i == 3) ? 3'b001 : 3'b000)) begin
            fails++; $display("FAIL step_frame_done[%0d]: got %b, expected %b", i, f, (i == 3) ? 3'b001 : 3'b000);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [29:0] ea [6] = '{30'h1000, 30'h20000, 30'h3FFFF800, 30'h1A00, 30'h20A00, 30'h200};
      logic [N-1:0] exp_oh;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
      req = 3'b111;
      for (int t = 0; t < 300 && dn_val.size() < 6; t++) @(negedge clk);
      req = '0;
      tests++;
      if (dn_val.size() < 6 || st_addr.size() < 6) begin
         fails++; $display("FAIL rr_timeout: got %0d done, expected 6", dn_val.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            exp_oh = 3'b001 << (i % 3);
            tests++;
            if (st_grant[i] !== exp_oh) begin fails++; $display("FAIL rr_grant[%0d]: got %b, expected %b", i, st_grant[i], exp_oh); end
            tests++;
            if (st_addr[i] !== ea[i]) begin fails++; $display("FAIL rr_addr[%0d]: got %h, expected %h", i, st_addr[i], ea[i]); end
            tests++;
            if (dn_val[i] !== exp_oh) begin fails++; $display("FAIL rr_done[%0d]: got %b, expected %b", i, dn_val[i], exp_oh); end
         end
         for (int i = 1; i < 6; i++) begin
            tests++;
            if (st_cyc[i] - st_cyc[i-1] != 14) begin
               fails++; $display("FAIL rr_gap[%0d]: got %0d, expected 14", i, st_cyc[i] - st_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_restart_xfer();
      logic [N-1:0]     em [5] = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b001};
      int               rs [5] = '{4, -1, -1, 4, -1};
      logic [29:0]      ea [5] = '{30'h21400, 30'h20000, 30'h2400, 30'h2E00, 30'h1000};
      int               el [5] = '{2, 0, 2, 3, 0};
      logic [29:0]      a;
      logic [LBITS-1:0] l;
      logic [N-1:0]     d, f;
      bit               ok;
      for (int i = 0; i < 5; i++) begin
         drive_line(em[i], rs[i], a, l, d, f, ok);
         tests++;
         if (!ok) begin fails++; $display("FAIL restart_timeout[%0d]: got no done, expected one", i); end
         tests++;
         if (a !== ea[i]) begin fails++; $display("FAIL restart_addr[%0d]: got %h, expected %h", i, a, ea[i]); end
         tests++;
         if (l !== LBITS'(el[i])) begin fails++; $display("FAIL restart_line[%0d]: got %0d, expected %0d", i, l, el[i]); end
         tests++;
         if (d !== em[i]) begin fails++; $display("FAIL restart_done[%0d]: got %b, expected %b", i, d, em[i]); end
         tests++;
         if (f !== 3'b000) begin fails++; $display("FAIL restart_frame_done[%0d]: got %b, expected 000", i, f); end
      end
   endtask

   task automatic test_reset_mid();
      logic [29:0]      a;
      logic [LBITS-1:0] l;
      logic [N-1:0]     d, f;
      bit               ok;
      clear_logs();
      req = 3'b001;
      for (int t = 0; t < 50 && st_addr.size() < 1; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if ({grant, done, frame_done, line_idx, rd_start, rd_addr} !== '0) begin
         fails++;
         $display("FAIL reset_mid_outputs: got grant=%b line=%0d start=%b addr=%h, expected all 0",
                  grant, line_idx, rd_start, rd_addr);
      end
      @(negedge clk);
      rst = 1'b0; req = '0;
      // pointer back at 0 picks client 0 over client 2
      drive_line(3'b101, -1, a, l, d, f, ok);
      tests++;
      if (!ok || a !== 30'h1000 || d !== 3'b001) begin
         fails++; $display("FAIL reset_mid_first: got addr=%h done=%b, expected addr=00001000 done=001", a, d);
      end
      drive_line(3'b100, -1, a, l, d, f, ok);
      tests++;
      if (!ok || a !== 30'h3FFFF800 || l !== '0) begin
         fails++; $display("FAIL reset_mid_client2: got addr=%h line=%0d, expected 3ffff800 line 0", a, l);
      end
   endtask

   task automatic test_calib_loss();
      clear_logs();
      req = 3'b010;
      for (int t = 0; t < 50 && st_addr.size() < 1; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      mem_calib_done = 1'b0;
      for (int t = 0; t < 50 && dn_val.size() < 1; t++) @(negedge clk);
      tests++;
      if (dn_val.size() < 1 || dn_val[0] !== 3'b010) begin
         fails++; $display("FAIL calib_loss_done: got %0d pulses, expected done=010", dn_val.size());
      end
      repeat (20) @(negedge clk);
      tests++;
      if (st_addr.size() != 1) begin
         fails++; $display("FAIL calib_loss_hold: got %0d starts, expected 1", st_addr.size());
      end
      mem_calib_done = 1'b1;
      for (int t = 0; t < 50 && st_addr.size() < 2; t++) @(negedge clk);
      tests++;
      if (st_addr.size() < 2 || st_addr[1] !== 30'h20A00) begin
         fails++; $display("FAIL calib_loss_resume: got %0d starts, expected second at 00020a00", st_addr.size());
      end
      for (int t = 0; t < 50 && dn_val.size() < 2; t++) @(negedge clk);
      req = '0;
   endtask

   initial begin
      rst = 1'b1;
      base_addr = {30'h3FFFF800, 30'h0002_0000, 30'h0000_1000};
      test_reset();
      test_calib_gate();
      test_line_step();
      test_round_robin();
      test_restart_xfer();
      test_reset_mid();
      test_calib_loss();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
